// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, h/v counters, sync/de decode, line/frame strobes.
// Optional macro VGA_PIX_SCALE_EN adds registered scaled coordinates px_x/px_y.
module vga_timing_gen #(
    parameter int unsigned CW          = 10,
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter logic        HSYNC_POL   = 1'b0,
    parameter logic        VSYNC_POL   = 1'b0,
    parameter int unsigned SCALE_SHIFT = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_PIX_SCALE_EN
    ,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if ((H_TOTAL - 1) >= (2 ** CW) || (V_TOTAL - 1) >= (2 ** CW)) begin : g_chk_cw
        $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
    end
    if (SCALE_SHIFT >= CW) begin : g_chk_scale
        $error("vga_timing_gen: SCALE_SHIFT must be smaller than CW");
    end

    logic [DW-1:0] r_div;
    logic          r_pix_en;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic [DW-1:0] w_div_nxt;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic [CW-1:0] w_h_nxt;
    logic [CW-1:0] w_v_nxt;
    logic [31:0]   w_hx;
    logic [31:0]   w_vx;
    logic          w_hs_act;
    logic          w_vs_act;

    always_comb begin
        w_div_nxt = (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
        w_h_wrap  = (r_h == H_MAX);
        w_v_wrap  = (r_v == V_MAX);
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (r_pix_en) begin
            w_h_nxt = w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? '0 : r_v + 1'b1;
            end
        end
        // Decode from next-state counts so registered syncs/de line up with the counters.
        w_hx     = 32'(w_h_nxt);
        w_vx     = 32'(w_v_nxt);
        w_hs_act = (w_hx >= HS_BEG) && (w_hx < HS_END);
        w_vs_act = (w_vx >= VS_BEG) && (w_vx < VS_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_pix_en      <= (CLK_DIV == 1);
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~HSYNC_POL;
            r_vsync       <= ~VSYNC_POL;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_pix_en      <= (w_div_nxt == DIV_MAX);
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
            r_de          <= (w_hx < H_ACTIVE) && (w_vx < V_ACTIVE);
            r_line_start  <= r_pix_en && w_h_wrap;
            r_frame_start <= r_pix_en && w_h_wrap && w_v_wrap;
        end
    end

    assign pix_en      = r_pix_en;
    assign h_count     = r_h;
    assign v_count     = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_PIX_SCALE_EN
    logic [CW-1:0] r_px_x;
    logic [CW-1:0] r_px_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px_x <= '0;
            r_px_y <= '0;
        end else begin
            r_px_x <= w_h_nxt >> SCALE_SHIFT;
            r_px_y <= w_v_nxt >> SCALE_SHIFT;
        end
    end

    assign px_x = r_px_x;
    assign px_y = r_px_y;
`endif

endmodule
